therm_bubble_corrector: RTL and testbench
=========================================

Name: therm_bubble_corrector

Overview:
Upstream stage of the flash ADC thermometer-to-binary priority encoder. Synchronises the raw comparator bank outputs into the clk domain and captures one sample per sample strobe. Applies 3-input majority bubble correction and presents a registered thermometer word with a valid pulse. Keeps a saturating bubble-event counter for characterisation.

Parameters:
N, 255, number of comparators / thermometer width (matches encoder input)
SYNC_STAGES, 2, synchroniser flops per comparator bit (legal 2..4)
ERR_CNT_W, 16, width of bubble event counter

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  synchronous active-low reset
comp_in  input  N  raw comparator outputs, asynchronous to clk
sample_en  input  1  capture strobe, one sample per cycle it is high
cnt_clr  input  1  synchronous clear of bubble_cnt
therm_out  output  N  bubble-corrected thermometer code, bit i = comparator i
therm_valid  output  1  one-cycle pulse, therm_out holds a new sample
bubble_det  output  1  qualifies therm_valid, correction changed at least one bit
bubble_cnt  output  ERR_CNT_W  saturating count of samples with bubble_det=1

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge): sync chain, capture reg, therm_out=0, therm_valid=0, bubble_det=0, bubble_cnt=0, internal valid stage=0.
- Sync chain: SYNC_STAGES flops per bit, shifts every cycle regardless of sample_en. comp_in is captured SYNC_STAGES edges after it settles.
- Stage 1 (edge E where sample_en=1): cap <= sync_out; v1 <= 1. If sample_en=0: cap holds, v1 <= 0.
- Stage 2 (edge E+1): therm_out[i] <= maj(cap[i-1], cap[i], cap[i+1]). Boundary padding: cap[-1]=1, cap[N]=0, so bit0 = cap0|cap1 and bitN-1 = capN-2&capN-1. therm_valid <= v1. bubble_det <= v1 & (corrected != cap).
- Latency: sample_en at edge E -> therm_valid high in the cycle after edge E+1. Fully pipelined; sample_en every cycle gives therm_valid every cycle, with order preserved.
- therm_out holds its last value when therm_valid=0. bubble_det=0 whenever therm_valid=0.
- Correction covers isolated single-bit bubbles only. A run of two or more zeros/ones passes uncorrected and is not flagged. The downstream encoder resolves this by taking the highest set bit.
- bubble_cnt: +1 on each cycle with bubble_det=1, saturates at 2^ERR_CNT_W-1.
- cnt_clr has priority: if cnt_clr=1 and bubble_det=1 in the same cycle, bubble_cnt=0.
- Reset mid-operation: samples in flight are discarded; no therm_valid is produced for them after reset releases.
- No backpressure. The consumer must accept every therm_valid pulse.

Decomposition:
- Shared package adc_pkg holds N_COMP=255, BIN_W=8 (encoder output width), and a maj3 function. The encoder and this block share N_COMP.
- One sub-module, therm_sync: a parameterised SYNC_STAGES-deep N-bit synchroniser chain with synchronous active-low reset.
- Capture, majority and counter logic live in the top module.

Test Plan:
- comp_in = bits[99:0]=1, all others 0, held 3 cycles, then one sample_en -> 2 edges later one therm_valid pulse; therm_out = same pattern; bubble_det=0; bubble_cnt=0.
- bits[99:0]=1 except bit50=0 -> therm_out bits[99:0] all 1; bubble_det=1; bubble_cnt=1.
- bits[99:0]=1 plus isolated bit150=1 -> bit150 cleared in therm_out; bubble_det=1. Same test with bit0=0, bit1=1 (lower boundary): bit0 corrected to 1.
- bits[99:0]=1 except bits50,51=0 -> therm_out equals input; bubble_det=0 (documented limit). All-ones input -> bit254 stays 1. All-zeros input -> output all 0.
- sample_en high 10 consecutive cycles with comp_in stepping through 10 codes -> 10 consecutive therm_valid pulses, in the same order, 2-cycle offset.
- ERR_CNT_W=4, 20 bubbled samples -> bubble_cnt holds 15. cnt_clr coincident with bubble_det -> bubble_cnt=0. rst_n=0 for one edge between capture and output -> no therm_valid; all outputs 0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the flash ADC front end: comparator count, encoder
// output width and the majority vote used for bubble correction.
package adc_pkg;

  localparam int N_COMP = 255;
  localparam int BIN_W  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/therm_sync.sv
// Multi-flop synchroniser for the comparator bank; every bit gets its own
// STAGES-deep chain and the chain shifts on every clock.
module therm_sync #(
  parameter int W      = 255,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        chain[s] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++) begin
        chain[s] <= chain[s-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/therm_bubble_corrector.sv
// Captures synchronised comparator samples on sample_en, applies 3-input
// majority bubble correction and counts corrected samples.
module therm_bubble_corrector
  import adc_pkg::*;
#(
  parameter int N           = N_COMP,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         comp_in,
  input  logic                 sample_en,
  input  logic                 cnt_clr,
  output logic [N-1:0]         therm_out,
  output logic                 therm_valid,
  output logic                 bubble_det,
  output logic [ERR_CNT_W-1:0] bubble_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [N-1:0] sync_out;
  logic [N-1:0] cap;
  logic         v1;
  logic [N+1:0] padded;
  logic [N-1:0] corrected;

  therm_sync #(
    .W      (N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_in),
    .q     (sync_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap <= '0;
      v1  <= 1'b0;
    end else begin
      v1 <= sample_en;
      if (sample_en) begin
        cap <= sync_out;
      end
    end
  end

  // Below bit 0 the code is treated as a 1 and above the top bit as a 0,
  // so the end bits vote against a single real neighbour.
  assign padded = {1'b0, cap, 1'b1};

  always_comb begin
    corrected = '0;
    for (int i = 0; i < N; i++) begin
      corrected[i] = maj3(padded[i], padded[i+1], padded[i+2]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      therm_out   <= '0;
      therm_valid <= 1'b0;
      bubble_det  <= 1'b0;
    end else begin
      therm_valid <= v1;
      bubble_det  <= v1 & (corrected != cap);
      if (v1) begin
        therm_out <= corrected;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (bubble_det && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_therm_bubble_corrector.sv
// Directed-vector bench for therm_bubble_corrector with hand-computed
// expectations; the counter is narrowed to 4 bits to reach saturation.
module tb_therm_bubble_corrector;

  localparam int N = 255;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  comp_in;
  logic          sample_en;
  logic          cnt_clr;
  logic [N-1:0]  therm_out;
  logic          therm_valid;
  logic          bubble_det;
  logic [CW-1:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] p100;
  logic [N-1:0] bub50;
  logic [N-1:0] codes [10];
  int           det_pulses;

  therm_bubble_corrector #(
    .N           (N),
    .SYNC_STAGES (2),
    .ERR_CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .comp_in     (comp_in),
    .sample_en   (sample_en),
    .cnt_clr     (cnt_clr),
    .therm_out   (therm_out),
    .therm_valid (therm_valid),
    .bubble_det  (bubble_det),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Leaves the bench at the negedge just after the capture edge.
  task automatic applyStimulus(input logic [N-1:0] pattern);
    @(negedge clk);
    comp_in = pattern;
    repeat (3) @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic checkSample(input string tag, input logic [N-1:0] exp_out,
                             input logic exp_det, input logic [CW-1:0] exp_cnt);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 256'(therm_valid), 256'(1'b1));
    checkOutput({tag, "_out"}, 256'(therm_out), 256'(exp_out));
    checkOutput({tag, "_det"}, 256'(bubble_det), 256'(exp_det));
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, 256'(therm_valid), 256'(1'b0));
    checkOutput({tag, "_det_drop"}, 256'(bubble_det), 256'(1'b0));
    checkOutput({tag, "_cnt"}, 256'(bubble_cnt), 256'(exp_cnt));
  endtask

  initial begin
    rst_n     = 1'b0;
    comp_in   = '0;
    sample_en = 1'b0;
    cnt_clr   = 1'b0;

    p100 = '0;
    for (int i = 0; i < 100; i++) p100[i] = 1'b1;
    bub50 = p100;
    bub50[50] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      codes[k] = '0;
      for (int i = 0; i < 10 * k + 5; i++) codes[k][i] = 1'b1;
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", 256'(therm_valid), 256'(1'b0));
    checkOutput("rst_out", 256'(therm_out), 256'(0));
    checkOutput("rst_det", 256'(bubble_det), 256'(1'b0));
    checkOutput("rst_cnt", 256'(bubble_cnt), 256'(0));
    rst_n = 1'b1;

    $display("[TB] single-sample correction vectors");
    applyStimulus(p100);
    checkSample("clean100", p100, 1'b0, 4'd0);

    applyStimulus(bub50);
    checkSample("hole50", p100, 1'b1, 4'd1);

    begin
      logic [N-1:0] v;
      v = p100;
      v[150] = 1'b1;
      applyStimulus(v);
      checkSample("spike150", p100, 1'b1, 4'd2);

      v = p100;
      v[0] = 1'b0;
      applyStimulus(v);
      checkSample("low_edge", p100, 1'b1, 4'd3);

      v = p100;
      v[50] = 1'b0;
      v[51] = 1'b0;
      applyStimulus(v);
      checkSample("double_hole", v, 1'b0, 4'd3);
    end

    applyStimulus({N{1'b1}});
    @(negedge clk);
    checkOutput("ones_valid", 256'(therm_valid), 256'(1'b1));
    checkOutput("ones_out", 256'(therm_out), 256'({N{1'b1}}));
    checkOutput("ones_bit254", 256'(therm_out[254]), 256'(1'b1));
    checkOutput("ones_det", 256'(bubble_det), 256'(1'b0));

    applyStimulus('0);
    checkSample("zeros", '0, 1'b0, 4'd3);

    $display("[TB] back-to-back stream");
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      checkOutput($sformatf("stream_valid_%0d", cyc), 256'(therm_valid),
                  256'((cyc >= 4 && cyc <= 13) ? 1'b1 : 1'b0));
      if (cyc >= 4 && cyc <= 13)
        checkOutput($sformatf("stream_out_%0d", cyc), 256'(therm_out), 256'(codes[cyc-4]));
      if (cyc < 10) comp_in = codes[cyc];
      sample_en = (cyc >= 2 && cyc <= 11);
    end
    sample_en = 1'b0;

    $display("[TB] counter saturation");
    @(negedge clk);
    comp_in = bub50;
    repeat (3) @(negedge clk);
    det_pulses = 0;
    for (int cyc = 0; cyc < 26; cyc++) begin
      sample_en = (cyc < 20);
      @(negedge clk);
      if (therm_valid && bubble_det) det_pulses++;
    end
    sample_en = 1'b0;
    checkOutput("sat_pulses", 256'(det_pulses), 256'(20));
    checkOutput("sat_cnt", 256'(bubble_cnt), 256'(15));

    $display("[TB] clear coincident with bubble");
    applyStimulus(bub50);
    @(negedge clk);
    checkOutput("clr_det", 256'(bubble_det), 256'(1'b1));
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    checkOutput("clr_cnt", 256'(bubble_cnt), 256'(0));
    @(negedge clk);
    checkOutput("clr_cnt_hold", 256'(bubble_cnt), 256'(0));

    applyStimulus(bub50);
    checkSample("post_clr", p100, 1'b1, 4'd1);

    $display("[TB] reset between capture and output");
    applyStimulus(bub50);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_valid", 256'(therm_valid), 256'(1'b0));
    checkOutput("midrst_out", 256'(therm_out), 256'(0));
    checkOutput("midrst_det", 256'(bubble_det), 256'(1'b0));
    checkOutput("midrst_cnt", 256'(bubble_cnt), 256'(0));
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_after_%0d", cyc), 256'(therm_valid), 256'(1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
